// File: rtl/traffic_timing_config_if.sv
// Keypad-to-config and config-to-Sistema/Saida signal bundle for traffic_timing_config.
// slave = the configuration block, master = keypad side / consumers (or a testbench).
interface traffic_timing_config_if;
    // Handshake: key is valid while dav is high and must be stable for that whole time.
    // The block takes one key per low-to-high dav transition and has no ready.
    // A new key therefore needs dav low for at least one sampled clock first.
    logic       dav;
    logic [3:0] key;
    logic [6:0] Tpv;
    logic [6:0] Tsv;
    logic [6:0] Ta;
    logic [1:0] PhraseSel;
    logic [1:0] entry_target;
    logic [6:0] entry_value;
    logic       cfg_active;
    logic       cfg_update;
    logic [2:0] dbg_state;

    modport slave (
        input  dav, key,
        output Tpv, Tsv, Ta, PhraseSel, entry_target, entry_value,
               cfg_active, cfg_update, dbg_state
    );

    modport master (
        output dav, key,
        input  Tpv, Tsv, Ta, PhraseSel, entry_target, entry_value,
               cfg_active, cfg_update, dbg_state
    );
endinterface

// File: rtl/traffic_timing_config.sv
// Keypad menu sequencer that edits the Tpv/Tsv/Ta phase-time registers.
// Define CFG_TIMEOUT_EN to abandon an entry after TIMEOUT_CYCLES cycles without a key.
module traffic_timing_config #(
    parameter int TPV_DEFAULT    = 30,
    parameter int TSV_DEFAULT    = 20,
    parameter int TA_DEFAULT     = 3,
    parameter int T_MIN          = 1,
    parameter int T_MAX          = 99,
    parameter int ERR_HOLD       = 2,
    parameter int TIMEOUT_CYCLES = 10
) (
    input logic                    clock,
    input logic                    reset,
    traffic_timing_config_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_TENS    = 3'd2,
        S_UNITS   = 3'd3,
        S_CONFIRM = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam int         ERR_W    = $clog2(ERR_HOLD) + 1;

    state_t           state_q, state_d;
    logic             dav_q;
    logic             armed_q;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [6:0]       tpv_q, tpv_d;
    logic [6:0]       tsv_q, tsv_d;
    logic [6:0]       ta_q, ta_d;
    logic [1:0]       phrase_q, phrase_d;
    logic [1:0]       target_q, target_d;
    logic [6:0]       value_q, value_d;
    logic             active_q, active_d;
    logic             update_q, update_d;

    logic accept;
    logic is_digit;
    logic in_range;
    logic commit_ok;

`ifdef CFG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // armed_q blocks a dav that is already high when reset releases.
    assign accept   = bus.dav & ~dav_q & armed_q;
    assign is_digit = (bus.key <= 4'd9);
    assign in_range = (value_q >= 7'(T_MIN)) && (value_q <= 7'(T_MAX));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            dav_q     <= 1'b0;
            armed_q   <= 1'b0;
            err_cnt_q <= '0;
            tpv_q     <= 7'(TPV_DEFAULT);
            tsv_q     <= 7'(TSV_DEFAULT);
            ta_q      <= 7'(TA_DEFAULT);
            phrase_q  <= 2'd0;
            target_q  <= 2'd0;
            value_q   <= 7'd0;
            active_q  <= 1'b0;
            update_q  <= 1'b0;
`ifdef CFG_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dav_q     <= bus.dav;
            armed_q   <= armed_q | ~bus.dav;
            err_cnt_q <= err_cnt_d;
            tpv_q     <= tpv_d;
            tsv_q     <= tsv_d;
            ta_q      <= ta_d;
            phrase_q  <= phrase_d;
            target_q  <= target_d;
            value_q   <= value_d;
            active_q  <= active_d;
            update_q  <= update_d;
`ifdef CFG_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        err_cnt_d = '0;
        commit_ok = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && bus.key == KEY_STAR) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (accept) begin
                    if (bus.key == KEY_STAR)                          state_d = S_IDLE;
                    else if (bus.key >= 4'd1 && bus.key <= 4'd3)      state_d = S_TENS;
                    else                                              state_d = S_ERROR;
                end
            end
            S_TENS: begin
                if (accept) begin
                    if (is_digit)                  state_d = S_UNITS;
                    else if (bus.key == KEY_STAR)  state_d = S_IDLE;
                    else                           state_d = S_ERROR;
                end
            end
            S_UNITS, S_CONFIRM: begin
                if (accept) begin
                    if (bus.key == KEY_HASH) begin
                        commit_ok = in_range;
                        state_d   = in_range ? S_IDLE : S_ERROR;
                    end else if (bus.key == KEY_STAR) begin
                        state_d = S_IDLE;
                    end else if (is_digit) begin
                        // A second digit moves UNITS on; further digits in CONFIRM are dropped.
                        state_d = S_CONFIRM;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_ERROR: begin
                if (err_cnt_q == ERR_W'(ERR_HOLD - 1)) state_d = S_IDLE;
                else                                   err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CFG_TIMEOUT_EN
        to_cnt_d = '0;
        if ((state_q inside {S_SELECT, S_TENS, S_UNITS, S_CONFIRM}) && !accept) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d  = S_IDLE;
            else                                       to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
    end

    always_comb begin
        target_d = target_q;
        value_d  = value_q;
        tpv_d    = tpv_q;
        tsv_d    = tsv_q;
        ta_d     = ta_q;
        if (state_d == S_IDLE) begin
            target_d = 2'd0;
            value_d  = 7'd0;
        end else if (state_q == S_SELECT && state_d == S_TENS) begin
            target_d = bus.key[1:0];
            value_d  = 7'd0;
        end else if (state_q == S_TENS && state_d == S_UNITS) begin
            value_d = {3'b000, bus.key};
        end else if (state_q == S_UNITS && state_d == S_CONFIRM) begin
            value_d = value_q * 7'd10 + {3'b000, bus.key};
        end

        if (commit_ok) begin
            case (target_q)
                2'd1:    tpv_d = value_q;
                2'd2:    tsv_d = value_q;
                2'd3:    ta_d  = value_q;
                default: tpv_d = tpv_q;
            endcase
        end

        update_d = commit_ok;
        active_d = (state_d != S_IDLE);
        case (state_d)
            S_IDLE:   phrase_d = 2'd0;
            S_SELECT: phrase_d = 2'd1;
            S_ERROR:  phrase_d = 2'd3;
            default:  phrase_d = 2'd2;
        endcase
    end

    assign bus.Tpv          = tpv_q;
    assign bus.Tsv          = tsv_q;
    assign bus.Ta           = ta_q;
    assign bus.PhraseSel    = phrase_q;
    assign bus.entry_target = target_q;
    assign bus.entry_value  = value_q;
    assign bus.cfg_active   = active_q;
    assign bus.cfg_update   = update_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_traffic_timing_config.sv
// Directed bench for traffic_timing_config: commits are predicted into a queue and a
// monitor checks each cfg_update pulse against it; menu state is checked inline.
module tb_traffic_timing_config;
    localparam int ST_IDLE    = 0;
    localparam int ST_SELECT  = 1;
    localparam int ST_TENS    = 2;
    localparam int ST_UNITS   = 3;
    localparam int ST_CONFIRM = 4;
    localparam int ST_ERROR   = 5;
    localparam logic [3:0] K_STAR = 4'd10;
    localparam logic [3:0] K_HASH = 4'd11;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    logic [20:0] exp_q[$];

    traffic_timing_config_if bus();

    traffic_timing_config dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ui(input string tag, input int st, input int ph, input int tg, input int val);
        check({tag, "_state"},  32'(bus.dbg_state),    st);
        check({tag, "_phrase"}, 32'(bus.PhraseSel),    ph);
        check({tag, "_active"}, 32'(bus.cfg_active),   (st != ST_IDLE) ? 1 : 0);
        check({tag, "_target"}, 32'(bus.entry_target), tg);
        check({tag, "_value"},  32'(bus.entry_value),  val);
    endtask

    task automatic check_times(input string tag, input int tpv, input int tsv, input int ta);
        check({tag, "_Tpv"}, 32'(bus.Tpv), tpv);
        check({tag, "_Tsv"}, 32'(bus.Tsv), tsv);
        check({tag, "_Ta"},  32'(bus.Ta),  ta);
    endtask

    // driver: called at a negedge, returns at the negedge right after the acceptance edge
    task automatic key_down(input logic [3:0] k);
        bus.dav = 1'b1;
        bus.key = k;
        @(negedge clock);
        bus.dav = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        key_down(k);
        @(negedge clock);
    endtask

    task automatic push_commit(input int tpv, input int tsv, input int ta);
        exp_q.push_back({7'(tpv), 7'(tsv), 7'(ta)});
    endtask

    // monitor: every cfg_update cycle must match the oldest predicted commit
    always @(negedge clock) begin
        logic [20:0] want;
        logic [20:0] got;
        if (reset && bus.cfg_update) begin
            total++;
            got = {bus.Tpv, bus.Tsv, bus.Ta};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL commit_unexpected: cfg_update=1 with Tpv=%0d Tsv=%0d Ta=%0d, expected no pulse",
                         bus.Tpv, bus.Tsv, bus.Ta);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL commit_times: got Tpv=%0d Tsv=%0d Ta=%0d, expected Tpv=%0d Tsv=%0d Ta=%0d",
                             got[20:14], got[13:7], got[6:0], want[20:14], want[13:7], want[6:0]);
                end
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        bus.dav = 1'b0;
        bus.key = 4'd0;
        repeat (3) @(negedge clock);
        check_ui("rst", ST_IDLE, 0, 0, 0);
        check_times("rst", 30, 20, 3);
        check("rst_update", 32'(bus.cfg_update), 0);
        reset = 1'b1;
        @(negedge clock);

        // default path, with a digit ignored in CONFIRM
        press(K_STAR);  check_ui("t1_star", ST_SELECT, 1, 0, 0);
        press(4'd1);    check_ui("t1_sel", ST_TENS, 2, 1, 0);
        press(4'd4);    check_ui("t1_tens", ST_UNITS, 2, 1, 4);
        press(4'd5);    check_ui("t1_units", ST_CONFIRM, 2, 1, 45);
        press(4'd7);    check_ui("t1_extra", ST_CONFIRM, 2, 1, 45);
        push_commit(45, 20, 3);
        key_down(K_HASH);
        check_ui("t1_commit", ST_IDLE, 0, 0, 0);
        check_times("t1_commit", 45, 20, 3);
        check("t1_update_pulse", 32'(bus.cfg_update), 1);
        @(negedge clock);
        check("t1_update_end", 32'(bus.cfg_update), 0);

        // single-digit commit from UNITS, then out-of-range value
        press(K_STAR); press(4'd3); press(4'd7);
        check_ui("t2_units", ST_UNITS, 2, 3, 7);
        push_commit(45, 20, 7);
        key_down(K_HASH);
        check_times("t2_commit", 45, 20, 7);
        @(negedge clock);
        press(K_STAR); press(4'd2); press(4'd0); press(4'd0);
        check_ui("t2_zero", ST_CONFIRM, 2, 2, 0);
        key_down(K_HASH);
        check("t2_err1_phrase", 32'(bus.PhraseSel), 3);
        @(negedge clock);
        check("t2_err2_phrase", 32'(bus.PhraseSel), 3);
        @(negedge clock);
        check_ui("t2_err_done", ST_IDLE, 0, 0, 0);
        check_times("t2_err_done", 45, 20, 7);

        // held dav gives one acceptance
        bus.dav = 1'b1;
        bus.key = K_STAR;
        repeat (5) @(negedge clock);
        check_ui("t3_held", ST_SELECT, 1, 0, 0);
        bus.dav = 1'b0;
        @(negedge clock);
        press(K_STAR);
        check_ui("t3_cancel", ST_IDLE, 0, 0, 0);

        // invalid keys
        press(K_STAR); press(4'd2);
        key_down(K_HASH);
        check("t4_hash_tens", 32'(bus.dbg_state), ST_ERROR);
        repeat (2) @(negedge clock);
        check("t4_hash_back", 32'(bus.dbg_state), ST_IDLE);
        press(4'd13);
        check_ui("t4_idle_13", ST_IDLE, 0, 0, 0);
        press(K_STAR);
        key_down(4'd5);
        check("t4_bad_target", 32'(bus.PhraseSel), 3);
        repeat (2) @(negedge clock);
        press(K_STAR); press(4'd1);
        key_down(4'd14);
        check("t4_bad_code", 32'(bus.dbg_state), ST_ERROR);
        repeat (2) @(negedge clock);
        check("t4_bad_back", 32'(bus.PhraseSel), 0);

        // range limits 99 and 1
        press(K_STAR); press(4'd2); press(4'd9); press(4'd9);
        check_ui("b_99", ST_CONFIRM, 2, 2, 99);
        push_commit(45, 99, 7);
        press(K_HASH);
        press(K_STAR); press(4'd2); press(4'd0); press(4'd1);
        check_ui("b_01", ST_CONFIRM, 2, 2, 1);
        push_commit(45, 1, 7);
        press(K_HASH);
        check_times("b_01", 45, 1, 7);

        // asynchronous reset mid-entry, dav held across release
        press(K_STAR); press(4'd1); press(4'd9);
        check_ui("t5_mid", ST_UNITS, 2, 1, 9);
        #3 reset = 1'b0;
        #1;
        check_ui("t5_rst", ST_IDLE, 0, 0, 0);
        check_times("t5_rst", 30, 20, 3);
        check("t5_rst_update", 32'(bus.cfg_update), 0);
        bus.dav = 1'b1;
        bus.key = K_STAR;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_ui("t5_held_release", ST_IDLE, 0, 0, 0);
        bus.dav = 1'b0;
        @(negedge clock);

        // inactivity
        press(K_STAR); press(4'd2); press(4'd5);
        check_ui("t6_units", ST_UNITS, 2, 2, 5);
`ifdef CFG_TIMEOUT_EN
        repeat (8) @(negedge clock);
        check("t6_before_to", 32'(bus.dbg_state), ST_UNITS);
        @(negedge clock);
        check_ui("t6_timeout", ST_IDLE, 0, 0, 0);
        check_times("t6_timeout", 30, 20, 3);
`else
        repeat (50) @(negedge clock);
        check_ui("t6_wait", ST_UNITS, 2, 2, 5);
        press(K_STAR);
        check_ui("t6_cancel", ST_IDLE, 0, 0, 0);
        check_times("t6_cancel", 30, 20, 3);
`endif

        repeat (3) @(negedge clock);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/traffic_timing_config.md
# traffic_timing_config

Keypad-driven configuration sequencer for the traffic-light controller. Edge-detects the keypad `dav` strobe, runs a menu state machine that collects a target selection and a two-digit value, range-checks the value and commits it into one of the three phase-time registers (`Tpv`, `Tsv`, `Ta`). It sits between `Entrada` (keypad decode) and `Sistema`, which consumes the time registers. It also drives `PhraseSel` and the live entry value for the LCD path in `Saida`.

## Interface
- `TPV_DEFAULT`, 30: principal-green time after reset (s)
- `TSV_DEFAULT`, 20: secondary-green time after reset (s)
- `TA_DEFAULT`, 3: amber time after reset (s)
- `T_MIN`, 1: smallest value accepted on commit
- `T_MAX`, 99: largest value accepted on commit
- `ERR_HOLD`, 2: cycles spent in ERROR before returning to IDLE
- `TIMEOUT_CYCLES`, 10: inactivity limit; used only with `CFG_TIMEOUT_EN`

Ports:
- `clock`  in  1: the only clock, the 1 Hz system clock.
- `reset`  in  1: asynchronous, active-low.
- `dav`  in  1: key-valid level from the keypad scanner.
- `key`  in  4: key code. 0–9 are digits, 10 is `*` (menu/cancel), 11 is `#` (enter), 12–15 are invalid.
- `Tpv`, `Tsv`, `Ta`  out  7 each: committed phase times.
- `PhraseSel`  out  2: LCD prompt. 0 = normal, 1 = select target, 2 = digit entry, 3 = error.
- `entry_target`  out  2: 0 = none, 1 = Tpv, 2 = Tsv, 3 = Ta.
- `entry_value`  out  7: accumulated digits. 0 when no digit has been entered.
- `cfg_active`  out  1: high in every state except IDLE. `Sistema` freezes its phase timer while this is high.
- `cfg_update`  out  1: one-cycle pulse after a commit.

## Operation
- **Key acceptance:** a key is accepted on an edge where `dav`=1 and the registered `dav_q`=0. Holding `dav` high yields exactly one acceptance. All transitions below happen on the acceptance edge.
- **IDLE:** `*` goes to SELECT. All other keys are ignored.
- **SELECT:** key 1/2/3 sets `entry_target` to 1/2/3, clears `entry_value` and goes to TENS. `*` goes to IDLE. Any other key goes to ERROR.
- **TENS:** digit d sets `entry_value`=d and goes to UNITS. `#` goes to ERROR (nothing entered). `*` goes to IDLE. Invalid codes go to ERROR.
- **UNITS:** digit d sets `entry_value`=`entry_value`*10+d (7-bit, maximum 99) and goes to CONFIRM. `#` commits. `*` goes to IDLE. Invalid codes go to ERROR.
- **CONFIRM:** `#` commits. `*` goes to IDLE. Digits are ignored. Invalid codes go to ERROR.
- **Commit:**
  - If `T_MIN` ≤ `entry_value` ≤ `T_MAX`: write the target register, assert `cfg_update` and go to IDLE.
  - Otherwise go to ERROR and leave the register unchanged.
- **ERROR:** stays for `ERR_HOLD` cycles with keys ignored, then goes to IDLE.
- **Entering IDLE from any state:** `entry_target`=0 and `entry_value`=0.
- **`PhraseSel` by state:** IDLE 0, SELECT 1, TENS/UNITS/CONFIRM 2, ERROR 3.
- **Reset (asserted at any time, including mid-entry):** state IDLE; `Tpv`/`Tsv`/`Ta` = defaults; `PhraseSel`=0; `entry_target`=0; `entry_value`=0; `cfg_active`=0; `cfg_update`=0; `dav_q`=0. A `dav` already high when reset releases is not accepted.

## Timing
- All outputs are registered.
- State outputs change on the acceptance edge.
- The time register updates on the commit edge. `cfg_update` is high for exactly the one cycle following that edge.
- At most one key is accepted per cycle. A new key needs `dav` low for at least one sampled cycle first.
- ERROR lasts exactly `ERR_HOLD` cycles. `PhraseSel` returns to 0 on the following edge.

## Configuration
- **`CFG_TIMEOUT_EN` defined:**
  - An inactivity counter clears on every accepted key.
  - In SELECT/TENS/UNITS/CONFIRM, after `TIMEOUT_CYCLES` consecutive cycles with no accepted key, the block returns to IDLE. No commit happens and `cfg_update` stays 0.
  - The counter is held at 0 in IDLE and ERROR.
- **`CFG_TIMEOUT_EN` undefined:** no counter. Entry states wait indefinitely.

## Test plan
- **Default path:** reset, then `*`,`1`,`4`,`5`,`#` → `Tpv`=45 and one `cfg_update` pulse. `Tsv`=20 and `Ta`=3 unchanged. Final `PhraseSel`=0.
- **Single digit:** `*`,`3`,`7`,`#` → `Ta`=7. Then `*`,`2`,`0`,`0`,`#` → ERROR (`PhraseSel`=3) for 2 cycles, `Tsv` stays 20, no `cfg_update`.
- **Held `dav`:** keep `dav` high for 5 cycles with key=10 → exactly one transition to SELECT. `*` again → IDLE with `cfg_active`=0.
- **Invalid keys:** `*`,`2`,`#` → ERROR. Key 13 in IDLE → ignored, stays IDLE.
- **Reset mid-entry:** `*`,`1`,`9` then pull `reset` low → all outputs return to reset values immediately, `Tpv`=30.
- **Timeout (`CFG_TIMEOUT_EN`):** `*`,`2`,`5`, then 10 idle cycles → IDLE, `Tsv`=20, `cfg_update` never asserted. Without the macro, still in UNITS after 50 cycles.
